// File: rtl/filereg_fromnet_multiflit.sv
// Request FIFO and top level: NoC flits are assembled into register-file requests and sent out on an AXI-Stream initiator.
// Latency: request valid on tdata one cycle after its last flit is accepted; one flit per cycle sustained.
// Backpressure: network_ready drops only on the last flit of a request while the FIFO is full and not popping.
// Ports (fifo): clk_i/rst_ni; push/push_data in; pop in; full/empty/head out.
// Ports (top): clk_i/rst_ni; network_valid_i/network_ready_o/network_data_i flit side;
//              filereg_m_tvalid_o/tready_i/tdata_o/tlast_o request side; error_count_o discard counter.

module filereg_fromnet_multiflit_fifo #(
  parameter int Width = 64,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntWidth = $clog2(Depth) + 1;
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  // Storage is sized to the full pointer range so the index width always
  // matches; with Depth=1 the second entry is never addressed.
  logic [Width-1:0]    mem [2**PtrWidth];
  logic [PtrWidth-1:0] wptr;
  logic [PtrWidth-1:0] rptr;
  logic [CntWidth-1:0] count;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == DepthCnt);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == LastPtr) ? '0 : wptr + PtrWidth'(1);
      if (do_pop)  rptr <= (rptr == LastPtr) ? '0 : rptr + PtrWidth'(1);
      if (do_push && !do_pop)      count <= count + CntWidth'(1);
      else if (!do_push && do_pop) count <= count - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= push_data;
  end
endmodule

module filereg_fromnet_multiflit #(
  parameter int WordWidth                      = 32,
  parameter int FlitsPerRequest                = 2,
  parameter int RequestFifoDepth               = 2,
  parameter int HeaderFlitType                 = 0,
  parameter int ErrorCountWidth                = 8,
  parameter int NetworkIfFlitWidth             = 64,
  parameter int NetworkIfFlitTypeWidth         = 2,
  parameter int NetworkIfBroadcastWidth        = 1,
  parameter int NetworkIfVirtualNetworkIdWidth = 2,
  localparam int FileRegIfDataWidth = FlitsPerRequest * WordWidth,
  localparam int NetworkIfDataWidth = NetworkIfFlitWidth + NetworkIfFlitTypeWidth
                                    + NetworkIfBroadcastWidth + NetworkIfVirtualNetworkIdWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          network_valid_i,
  output logic                          network_ready_o,
  input  logic [NetworkIfDataWidth-1:0] network_data_i,
  output logic                          filereg_m_tvalid_o,
  input  logic                          filereg_m_tready_i,
  output logic [FileRegIfDataWidth-1:0] filereg_m_tdata_o,
  output logic                          filereg_m_tlast_o,
  output logic [ErrorCountWidth-1:0]    error_count_o
);
  localparam int WcWidth = (FlitsPerRequest > 1) ? $clog2(FlitsPerRequest) : 1;
  localparam logic [WcWidth-1:0] LastWc = WcWidth'(FlitsPerRequest - 1);
  localparam logic [NetworkIfFlitTypeWidth-1:0] HeaderType = NetworkIfFlitTypeWidth'(HeaderFlitType);

  logic [NetworkIfFlitWidth-1:0]                                     flit;
  logic [NetworkIfFlitTypeWidth-1:0]                                 flit_type;
  logic [NetworkIfBroadcastWidth+NetworkIfVirtualNetworkIdWidth-1:0] side_fields;
  logic                                                              unused_bits;
  logic [WordWidth-1:0]                                              word;

  logic [WcWidth-1:0]            wc;
  logic [FileRegIfDataWidth-1:0] asm_data;
  logic [FileRegIfDataWidth-1:0] shifted;
  logic                          acc;
  logic                          is_last;
  logic                          resync;
  logic                          push;
  logic                          pop;
  logic                          fifo_full;
  logic                          fifo_empty;

  // Broadcast, vn_id and flit bits above the word carry nothing for this block.
  assign {flit, flit_type, side_fields} = network_data_i;
  assign unused_bits = ^{flit, side_fields};
  assign word        = flit[WordWidth-1:0];

  assign pop     = filereg_m_tvalid_o & filereg_m_tready_i;
  assign is_last = (wc == LastWc);
  // Only the last flit can push, so only it needs room in the FIFO.
  assign network_ready_o = ~is_last | ~fifo_full | pop;
  assign acc     = network_valid_i & network_ready_o;
  assign resync  = acc & (flit_type == HeaderType) & (wc != '0);
  assign push    = acc & is_last & ~resync;

  // Truncating {asm, word} keeps the newest FlitsPerRequest words; with one
  // flit per request this degenerates to the word itself.
  assign shifted = FileRegIfDataWidth'({asm_data, word});

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wc            <= '0;
      error_count_o <= '0;
    end else if (acc) begin
      if (resync) begin
        // The header restarts the request as its word 0.
        wc <= WcWidth'(1);
        if (error_count_o != '1) error_count_o <= error_count_o + ErrorCountWidth'(1);
      end else if (is_last) begin
        wc <= '0;
      end else begin
        wc <= wc + WcWidth'(1);
      end
    end
  end

  // Assembly contents are meaningless after reset, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (acc) asm_data <= resync ? FileRegIfDataWidth'(word) : shifted;
  end

  filereg_fromnet_multiflit_fifo #(
    .Width (FileRegIfDataWidth),
    .Depth (RequestFifoDepth)
  ) u_req_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (shifted),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (filereg_m_tdata_o)
  );

  assign filereg_m_tvalid_o = ~fifo_empty;
  assign filereg_m_tlast_o  = 1'b1;
endmodule
